// File: rtl/dmem_pkg.sv
// ============================================================================
// dmem_pkg
// ----------------------------------------------------------------------------
// Shared types and constants for the data-side bus request controller:
//   dmem_state_t          - controller state encoding
//   DSIZE_B/DSIZE_H/DSIZE_W - bus transfer size codes
//   DMEM_TIMEOUT_DEFAULT  - default abort limit for the optional watchdog
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } dmem_state_t;

    localparam logic [1:0] DSIZE_B = 2'd0;
    localparam logic [1:0] DSIZE_H = 2'd1;
    localparam logic [1:0] DSIZE_W = 2'd2;

    localparam int DMEM_TIMEOUT_DEFAULT = 255;

endpackage

`default_nettype wire

// File: rtl/dmem_timeout_cnt.sv
// ============================================================================
// dmem_timeout_cnt
// ----------------------------------------------------------------------------
// Watchdog counter for an outstanding bus transaction. Only instantiated when
// DMEM_TIMEOUT_EN is defined.
// Ports:
//   clk        - clock
//   rst        - asynchronous active-low reset
//   clear_i    - force the count to zero (controller idle / done)
//   count_en_i - transaction outstanding, count this cycle
//   expired_o  - count has reached LIMIT while counting
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (count_en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // The controller leaves the counting states on expiry, so the counter
    // never needs to saturate.
    assign expired_o = count_en_i & (cnt_q == CNT_W'(LIMIT));

endmodule

`default_nettype wire

// File: rtl/dmem_req_ctrl.sv
// ============================================================================
// dmem_req_ctrl
// ----------------------------------------------------------------------------
// Data-side bus request controller. Issues the E-stage memory request as one
// SRAM-like bus transaction (data_req until data_addr_ok, then wait for
// data_data_ok), stalls the pipeline while it is outstanding, buffers load
// data and hands it to the M stage on the E->M advance. Transactions orphaned
// by a flush after address acceptance are drained and their data discarded.
//
// Optional feature macro: DMEM_TIMEOUT_EN - transaction watchdog that aborts
// after TIMEOUT_CYCLES and pulses bus_err. Without it bus_err is tied low.
//
// Ports:
//   clk, rst (async active-low)
//   req_validE/req_wrE/req_sizeE/req_addrE/req_wdataE/req_wstrbE - E request
//   pipe_stall, flush      - pipeline control in
//   mem_stall              - stall request out
//   mem_rdataM             - raw load word for the instruction in M
//   bus_err                - one-cycle timeout abort pulse
//   data_req/wr/size/addr/wdata/wstrb - bus request out
//   data_addr_ok/data_data_ok/data_rdata - bus response in
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_req_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_validE,
    input  logic        req_wrE,
    input  logic [1:0]  req_sizeE,
    input  logic [31:0] req_addrE,
    input  logic [31:0] req_wdataE,
    input  logic [3:0]  req_wstrbE,

    input  logic        pipe_stall,
    input  logic        flush,

    output logic        mem_stall,
    output logic [31:0] mem_rdataM,
    output logic        bus_err,

    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    dmem_state_t state_q, state_d;

    logic        req_q,   req_d;
    logic        wr_q,    wr_d;
    logic [1:0]  size_q,  size_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rbuf_q,  rbuf_d;
    logic [31:0] rdm_q,   rdm_d;

    logic        expired;

`ifdef DMEM_TIMEOUT_EN
    logic cnt_clear;
    logic cnt_en;

    // Counter is held at zero while idle, so it starts from zero on REQ entry
    // and keeps running across REQ -> WAIT/DRAIN.
    assign cnt_clear = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign cnt_en    = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                       (state_q == ST_DRAIN);

    dmem_timeout_cnt #(
        .LIMIT      (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (cnt_clear),
        .count_en_i (cnt_en),
        .expired_o  (expired)
    );
`else
    logic [31:0] unused_timeout_cycles;

    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign expired               = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            rbuf_q  <= 32'd0;
            rdm_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rbuf_q  <= rbuf_d;
            rdm_q   <= rdm_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        wr_d      = wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rbuf_d    = rbuf_q;
        rdm_d     = rdm_q;
        mem_stall = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mem_stall = req_validE & ~flush;
                if (req_validE && !flush) begin
                    req_d   = 1'b1;
                    wr_d    = req_wrE;
                    size_d  = req_sizeE;
                    addr_d  = req_addrE;
                    wdata_d = req_wdataE;
                    wstrb_d = req_wstrbE;
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                // Stall stays high under flush; the pipeline resolves priority.
                mem_stall = 1'b1;
                if (expired) begin
                    req_d   = 1'b0;
                    rbuf_d  = 32'd0;
                    state_d = ST_DONE;
                end else if (data_addr_ok) begin
                    req_d   = 1'b0;
                    state_d = flush ? ST_DRAIN : ST_WAIT;
                end else if (flush) begin
                    // Not yet accepted by the bus, so it can simply be withdrawn.
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT: begin
                mem_stall = 1'b1;
                if (expired) begin
                    rbuf_d  = 32'd0;
                    state_d = ST_DONE;
                end else if (data_data_ok) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (!wr_q) begin
                            rbuf_d = data_rdata;
                        end
                        state_d = ST_DONE;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DONE: begin
                // The E op is already served; wait here for the pipeline to
                // advance so the same op is not reissued.
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (!pipe_stall) begin
                    rdm_d   = rbuf_q;
                    state_d = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                mem_stall = req_validE;
                if (expired || data_data_ok) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign data_req   = req_q;
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign data_wstrb = wstrb_q;
    assign mem_rdataM = rdm_q;
    assign bus_err    = expired;

endmodule

`default_nettype wire

// File: tb/tb_dmem_req_ctrl.sv
// ============================================================================
// tb_dmem_req_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for dmem_req_ctrl: directed vector table, flush/reset
// corner sequences, randomized ops against a transaction-level model, and the
// watchdog case when DMEM_TIMEOUT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_req_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_validE, req_wrE;
    logic [1:0]  req_sizeE;
    logic [31:0] req_addrE, req_wdataE;
    logic [3:0]  req_wstrbE;
    logic        pipe_stall, flush;
    logic        mem_stall;
    logic [31:0] mem_rdataM;
    logic        bus_err;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    always #5 clk = ~clk;

    dmem_req_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_validE   (req_validE),
        .req_wrE      (req_wrE),
        .req_sizeE    (req_sizeE),
        .req_addrE    (req_addrE),
        .req_wdataE   (req_wdataE),
        .req_wstrbE   (req_wstrbE),
        .pipe_stall   (pipe_stall),
        .flush        (flush),
        .mem_stall    (mem_stall),
        .mem_rdataM   (mem_rdataM),
        .bus_err      (bus_err),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          a_dly;
        int          d_dly;
        int          ps;
        logic        hold;
        logic [31:0] exp_word;
        int          exp_stalls;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model: last completed load word, and what M sees.
    logic [31:0] rbuf_m = 32'd0;
    logic [31:0] word_m = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_op(input vec_t v);
        req_validE = 1'b1;
        req_wrE    = v.wr;
        req_sizeE  = v.size;
        req_addrE  = v.addr;
        req_wdataE = v.wdata;
        req_wstrbE = v.wstrb;
    endtask

    // Runs one op from the IDLE cycle that registers it through the E->M
    // advance. Entered and left shortly after a rising edge with the DUT idle.
    task automatic run_op(input vec_t v, output int stalls);
        stalls = 0;
        set_op(v);
        pipe_stall = v.hold;
        @(negedge clk);
        chk("e_data_req", {31'd0, data_req}, 32'd0);
        if (mem_stall) stalls++;
        @(posedge clk); #1;
        for (int k = 0; k <= v.a_dly; k++) begin
            data_addr_ok = (k == v.a_dly);
            @(negedge clk);
            chk("req_data_req", {31'd0, data_req}, 32'd1);
            chk("req_addr", data_addr, v.addr);
            chk("req_wdata", data_wdata, v.wdata);
            chk("req_ctl", {25'd0, data_wr, data_size, data_wstrb},
                {25'd0, v.wr, v.size, v.wstrb});
            chk("req_m_word", mem_rdataM, word_m);
            if (mem_stall) stalls++;
            @(posedge clk); #1;
        end
        data_addr_ok = 1'b0;
        for (int k = 0; k <= v.d_dly; k++) begin
            data_data_ok = (k == v.d_dly);
            data_rdata   = (k == v.d_dly) ? v.rdata : $urandom;
            @(negedge clk);
            chk("wait_data_req", {31'd0, data_req}, 32'd0);
            chk("wait_m_word", mem_rdataM, word_m);
            if (mem_stall) stalls++;
            @(posedge clk); #1;
        end
        data_data_ok = 1'b0;
        // E still presents the op while M is stalled; it must not reissue.
        for (int k = 0; k <= v.ps; k++) begin
            pipe_stall = (k < v.ps);
            @(negedge clk);
            chk("done_stall", {31'd0, mem_stall}, 32'd0);
            chk("done_no_req", {31'd0, data_req}, 32'd0);
            chk("done_m_word", mem_rdataM, word_m);
            chk("done_bus_err", {31'd0, bus_err}, 32'd0);
            @(posedge clk); #1;
        end
        req_validE = 1'b0;
        pipe_stall = 1'b0;
        if (!v.wr) rbuf_m = v.rdata;
        word_m = rbuf_m;
        #1;
        chk("adv_word", mem_rdataM, word_m);
        chk("stall_cycles", 32'(stalls), 32'(3 + v.a_dly + v.d_dly));
    endtask

    vec_t tbl[5];
    vec_t v;
    int   st;
    int   seen;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b0, DSIZE_W, 32'h8000_0010, 32'h0, 4'hF, 32'h1234_5678, 0, 0, 0, 1'b0, 32'h1234_5678, 3};
        tbl[1] = '{1'b1, DSIZE_B, 32'h8000_0003, 32'hAB00_0000, 4'b1000, 32'h5555_5555, 3, 0, 0, 1'b0, 32'h1234_5678, 6};
        tbl[2] = '{1'b0, DSIZE_H, 32'h8000_0022, 32'h0, 4'b1100, 32'hBEEF_0000, 1, 2, 2, 1'b0, 32'hBEEF_0000, 6};
        tbl[3] = '{1'b0, DSIZE_W, 32'h8000_0100, 32'h0, 4'hF, 32'h0000_000A, 0, 1, 0, 1'b0, 32'h0000_000A, 4};
        tbl[4] = '{1'b0, DSIZE_W, 32'h8000_0104, 32'h0, 4'hF, 32'h0000_000B, 2, 0, 1, 1'b1, 32'h0000_000B, 5};

        rst = 1'b0;
        req_validE = 1'b1; req_wrE = 1'b0; req_sizeE = 2'd0; req_addrE = 32'd0;
        req_wdataE = 32'd0; req_wstrbE = 4'd0; pipe_stall = 1'b0; flush = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;

        // Reset state
        @(negedge clk);
        chk("rst_stall_valid", {31'd0, mem_stall}, 32'd1);
        flush = 1'b1; #1;
        chk("rst_stall_flush", {31'd0, mem_stall}, 32'd0);
        chk("rst_req", {31'd0, data_req}, 32'd0);
        chk("rst_ctl", {25'd0, data_wr, data_size, data_wstrb}, 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        chk("rst_wdata", data_wdata, 32'd0);
        chk("rst_m_word", mem_rdataM, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        flush = 1'b0; req_validE = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i], st);
            chk("tbl_word", mem_rdataM, tbl[i].exp_word);
            chk("tbl_stalls", 32'(st), 32'(tbl[i].exp_stalls));
        end

        // Flush in REQ before acceptance: request withdrawn
        v = tbl[0]; v.addr = 32'h8000_0200;
        set_op(v);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("fl_req_data_req", {31'd0, data_req}, 32'd1);
        chk("fl_req_stall", {31'd0, mem_stall}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; req_validE = 1'b0;
        @(negedge clk);
        chk("fl_req_dropped", {31'd0, data_req}, 32'd0);
        chk("fl_req_idle", {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1;
        v.rdata = 32'h0BAD_F00D;
        run_op(v, st);

        // Flush on the accept cycle: drain, data discarded
        set_op(v);
        @(posedge clk); #1;
        flush = 1'b1; data_addr_ok = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; data_addr_ok = 1'b0; req_validE = 1'b1;
        @(negedge clk);
        chk("drain_req", {31'd0, data_req}, 32'd0);
        chk("drain_stall_valid", {31'd0, mem_stall}, 32'd1);
        req_validE = 1'b0; #1;
        chk("drain_stall_novalid", {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1;
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        @(negedge clk);
        chk("drain_m_word", mem_rdataM, word_m);
        @(posedge clk); #1;
        v.wr = 1'b1; v.wstrb = 4'b0011; v.wdata = 32'h0000_1111;
        run_op(v, st);

        // Flush with data_ok in WAIT: rbuf untouched, visible via a later store
        v.wr = 1'b0;
        set_op(v);
        @(posedge clk); #1;
        data_addr_ok = 1'b1; req_validE = 1'b0;
        @(posedge clk); #1;
        data_addr_ok = 1'b0; flush = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        flush = 1'b0; data_data_ok = 1'b0;
        @(negedge clk);
        chk("flwait_idle", {31'd0, mem_stall}, 32'd0);
        chk("flwait_m_word", mem_rdataM, word_m);
        @(posedge clk); #1;
        v.wr = 1'b1;
        run_op(v, st);

        // Randomized ops against the model
        for (int i = 0; i < 24; i++) begin
            v.wr    = 1'($urandom_range(0, 1));
            v.size  = 2'($urandom_range(0, 2));
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.wstrb = 4'($urandom);
            v.rdata = $urandom;
            v.a_dly = $urandom_range(0, 3);
            v.d_dly = $urandom_range(0, 3);
            v.ps    = $urandom_range(0, 2);
            v.hold  = 1'($urandom_range(0, 1));
            run_op(v, st);
        end

        // Asynchronous reset mid-transaction
        v = tbl[0];
        set_op(v);
        @(posedge clk); #1;
        req_validE = 1'b0;
        @(negedge clk);
        chk("mid_rst_pre", {31'd0, data_req}, 32'd1);
        rst = 1'b0; #1;
        chk("mid_rst_req", {31'd0, data_req}, 32'd0);
        chk("mid_rst_word", mem_rdataM, 32'd0);
        rbuf_m = 32'd0; word_m = 32'd0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        v.rdata = 32'h7777_0001;
        run_op(v, st);

`ifdef DMEM_TIMEOUT_EN
        // Watchdog: addr_ok never arrives
        set_op(v);
        @(posedge clk); #1;
        req_validE = 1'b0;
        seen = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus_err === 1'b1) begin
                seen = i;
                break;
            end
            @(posedge clk); #1;
        end
        chk("timeout_cycle", 32'(seen), 32'd8);
        @(posedge clk); #1;
        @(negedge clk);
        chk("timeout_pulse", {31'd0, bus_err}, 32'd0);
        chk("timeout_req", {31'd0, data_req}, 32'd0);
        chk("timeout_stall", {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1;
        chk("timeout_word", mem_rdataM, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
